// File: rtl/enemy_shooter.sv
// enemy_shooter: fleet gunner dropping one bomb at a time toward the player.
// Reports player hits and bomb/bullet clashes as single-cycle pulses.
module enemy_shooter #(
    parameter logic [11:0] color_p      = {4'hE, 4'h3, 4'h3},
    parameter logic [7:0]  lfsr_seed_p  = 8'hA5,
    parameter logic [7:0]  fire_delay_p = 8'd60,
    parameter logic [9:0]  step_p       = 10'd6,
    parameter logic [9:0]  player_top_p = 10'd394,
    parameter logic [9:0]  player_bot_p = 10'd414,
    parameter logic [9:0]  floor_p      = 10'd470
) (
    input  logic       clk_i,
    input  logic       reset_ni,
    input  logic       frame_i,
    input  logic       enable_i,
    input  logic       clear_i,
    input  logic [9:0] fleet_left_i,
    input  logic [9:0] fleet_right_i,
    input  logic [9:0] fleet_bot_i,
    input  logic [9:0] player_left_i,
    input  logic [9:0] player_right_i,
    input  logic       pbullet_i,
    input  logic [9:0] pbullet_left_i,
    input  logic [9:0] pbullet_top_i,
    output logic       hit_player_o,
    output logic       clash_o,
    output logic       bomb_o,
    output logic [9:0] bomb_left_o,
    output logic [9:0] bomb_right_o,
    output logic [9:0] bomb_top_o,
    output logic [9:0] bomb_bot_o,
    output logic [3:0] bomb_red_o,
    output logic [3:0] bomb_green_o,
    output logic [3:0] bomb_blue_o,
    output logic [1:0] state_o
);

    typedef enum logic [1:0] {
        S_IDLE = 2'b01,
        S_FALL = 2'b10
    } state_t;

    state_t      r_state;
    state_t      w_state_nxt;
    logic [7:0]  r_lfsr;
    logic [7:0]  r_cool;
    logic [7:0]  w_cool_nxt;
    logic [9:0]  r_left;
    logic [9:0]  r_top;
    logic [9:0]  w_left_nxt;
    logic [9:0]  w_top_nxt;
    logic        r_hit;
    logic        r_clash;
    logic        w_hit_nxt;
    logic        w_clash_nxt;

    logic        w_tick;
    logic [10:0] w_span;
    logic [9:0]  w_fire_left;
    logic [10:0] w_bl;
    logic [10:0] w_br;
    logic [10:0] w_bt;
    logic [10:0] w_bb;
    logic [10:0] w_pbl;
    logic [10:0] w_pbr;
    logic [10:0] w_pbt;
    logic [10:0] w_pbb;
    logic        w_hit;
    logic        w_clash;
    logic        w_floor;

    assign w_tick = frame_i & enable_i;

    // 11-bit sums so a wide fleet box cannot wrap the column clamp.
    assign w_span = {1'b0, fleet_left_i} + {3'b000, r_lfsr} + 11'd6;
    assign w_fire_left = (w_span <= {1'b0, fleet_right_i})
                       ? fleet_left_i + {2'b00, r_lfsr}
                       : fleet_right_i - 10'd6;

    assign w_bl  = {1'b0, r_left};
    assign w_br  = w_bl + 11'd6;
    assign w_bt  = {1'b0, r_top};
    assign w_bb  = w_bt + 11'd10;
    assign w_pbl = {1'b0, pbullet_left_i};
    assign w_pbr = w_pbl + 11'd6;
    assign w_pbt = {1'b0, pbullet_top_i};
    assign w_pbb = w_pbt + 11'd10;

    assign w_hit = (w_bl < {1'b0, player_right_i})
                 && (w_br > {1'b0, player_left_i})
                 && (w_bb >= {1'b0, player_top_p})
                 && (w_bt <= {1'b0, player_bot_p});

    assign w_clash = pbullet_i
                   && (w_bl < w_pbr) && (w_pbl < w_br)
                   && (w_bt < w_pbb) && (w_pbt < w_bb);

    assign w_floor = (r_top >= floor_p);

    // LFSR free-runs every clock, independent of enable and clear.
    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            r_lfsr <= lfsr_seed_p;
        end else begin
            r_lfsr <= {r_lfsr[6:0],
                       r_lfsr[7] ^ r_lfsr[5] ^ r_lfsr[4] ^ r_lfsr[3]};
        end
    end

    // State, cooldown, bomb position and pulse registers.
    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            r_state <= S_IDLE;
            r_cool  <= fire_delay_p;
            r_left  <= 10'd0;
            r_top   <= 10'd0;
            r_hit   <= 1'b0;
            r_clash <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_cool  <= w_cool_nxt;
            r_left  <= w_left_nxt;
            r_top   <= w_top_nxt;
            r_hit   <= w_hit_nxt;
            r_clash <= w_clash_nxt;
        end
    end

    // Next-state: clear beats hit beats clash beats floor beats move.
    always_comb begin
        w_state_nxt = r_state;
        w_cool_nxt  = r_cool;
        w_left_nxt  = r_left;
        w_top_nxt   = r_top;
        w_hit_nxt   = 1'b0;
        w_clash_nxt = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (clear_i) begin
                    w_cool_nxt = fire_delay_p;
                end else if (w_tick) begin
                    if (r_cool == 8'd0) begin
                        w_state_nxt = S_FALL;
                        w_left_nxt  = w_fire_left;
                        w_top_nxt   = fleet_bot_i;
                    end else begin
                        w_cool_nxt = r_cool - 8'd1;
                    end
                end
            end
            S_FALL: begin
                if (clear_i) begin
                    w_state_nxt = S_IDLE;
                    w_cool_nxt  = fire_delay_p;
                end else if (enable_i) begin
                    if (w_hit) begin
                        w_state_nxt = S_IDLE;
                        w_cool_nxt  = fire_delay_p;
                        w_hit_nxt   = 1'b1;
                    end else if (w_clash) begin
                        w_state_nxt = S_IDLE;
                        w_cool_nxt  = fire_delay_p;
                        w_clash_nxt = 1'b1;
                    end else if (w_floor) begin
                        w_state_nxt = S_IDLE;
                        w_cool_nxt  = fire_delay_p;
                    end else if (frame_i) begin
                        w_top_nxt = r_top + step_p;
                    end
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
                w_cool_nxt  = fire_delay_p;
            end
        endcase
    end

    assign hit_player_o = r_hit;
    assign clash_o      = r_clash;
    assign bomb_o       = (r_state == S_FALL);
    assign bomb_left_o  = r_left;
    assign bomb_right_o = r_left + 10'd6;
    assign bomb_top_o   = r_top;
    assign bomb_bot_o   = r_top + 10'd10;
    assign bomb_red_o   = color_p[11:8];
    assign bomb_green_o = color_p[7:4];
    assign bomb_blue_o  = color_p[3:0];
    assign state_o      = r_state;

endmodule

// File: tb/tb_enemy_shooter.sv
// tb_enemy_shooter: directed checks of firing, falling, hits and clashes.
// Expected values are hand-derived; column offsets come from an LFSR model.
module tb_enemy_shooter;

    logic       clk = 1'b0;
    logic       reset_ni;
    logic       frame_i;
    logic       enable_i;
    logic       clear_i;
    logic [9:0] fleet_left_i;
    logic [9:0] fleet_right_i;
    logic [9:0] fleet_bot_i;
    logic [9:0] player_left_i;
    logic [9:0] player_right_i;
    logic       pbullet_i;
    logic [9:0] pbullet_left_i;
    logic [9:0] pbullet_top_i;
    logic       hit_player_o;
    logic       clash_o;
    logic       bomb_o;
    logic [9:0] bomb_left_o;
    logic [9:0] bomb_right_o;
    logic [9:0] bomb_top_o;
    logic [9:0] bomb_bot_o;
    logic [3:0] bomb_red_o;
    logic [3:0] bomb_green_o;
    logic [3:0] bomb_blue_o;
    logic [1:0] state_o;

    int checks = 0;
    int failures = 0;
    int hit_cnt = 0;
    int clash_cnt = 0;
    logic [7:0] m_lfsr;
    logic [7:0] f_lfsr;

    always #5 clk = ~clk;

    enemy_shooter #(.fire_delay_p(8'd3)) dut (
        .clk_i          (clk),
        .reset_ni       (reset_ni),
        .frame_i        (frame_i),
        .enable_i       (enable_i),
        .clear_i        (clear_i),
        .fleet_left_i   (fleet_left_i),
        .fleet_right_i  (fleet_right_i),
        .fleet_bot_i    (fleet_bot_i),
        .player_left_i  (player_left_i),
        .player_right_i (player_right_i),
        .pbullet_i      (pbullet_i),
        .pbullet_left_i (pbullet_left_i),
        .pbullet_top_i  (pbullet_top_i),
        .hit_player_o   (hit_player_o),
        .clash_o        (clash_o),
        .bomb_o         (bomb_o),
        .bomb_left_o    (bomb_left_o),
        .bomb_right_o   (bomb_right_o),
        .bomb_top_o     (bomb_top_o),
        .bomb_bot_o     (bomb_bot_o),
        .bomb_red_o     (bomb_red_o),
        .bomb_green_o   (bomb_green_o),
        .bomb_blue_o    (bomb_blue_o),
        .state_o        (state_o)
    );

    // Reference LFSR: x^8+x^6+x^5+x^4+1, seed A5, steps every clock.
    always @(posedge clk or negedge reset_ni) begin
        if (!reset_ni) m_lfsr <= 8'hA5;
        else m_lfsr <= {m_lfsr[6:0],
                        m_lfsr[7] ^ m_lfsr[5] ^ m_lfsr[4] ^ m_lfsr[3]};
    end

    // Pulse tally, sampled away from the active edge.
    always @(negedge clk) begin
        if (reset_ni) begin
            if (hit_player_o) hit_cnt++;
            if (clash_o) clash_cnt++;
        end
    end

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    function automatic logic [9:0] exp_left(input int fl, input int fr,
                                            input int off);
        if (fl + off + 6 <= fr) return 10'(fl + off);
        return 10'(fr - 6);
    endfunction

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic frame_pulse;
        frame_i = 1'b1;
        f_lfsr = m_lfsr;
        @(negedge clk);
        frame_i = 1'b0;
    endtask

    task automatic frames(input int n);
        repeat (n) begin
            step(1);
            frame_pulse();
        end
    endtask

    initial begin
        reset_ni = 1'b0;
        frame_i = 1'b0;
        enable_i = 1'b1;
        clear_i = 1'b0;
        fleet_left_i = 10'd100;
        fleet_right_i = 10'd200;
        fleet_bot_i = 10'd200;
        player_left_i = 10'd9;
        player_right_i = 10'd49;
        pbullet_i = 1'b0;
        pbullet_left_i = 10'd0;
        pbullet_top_i = 10'd0;

        @(negedge clk);
        chk("rst_state", state_o, 2'b01);
        chk("rst_bomb", bomb_o, 0);
        chk("rst_left", bomb_left_o, 0);
        chk("rst_right", bomb_right_o, 6);
        chk("rst_bot", bomb_bot_o, 10);
        chk("rst_hit", hit_player_o, 0);
        chk("rst_clash", clash_o, 0);
        chk("colour", {bomb_red_o, bomb_green_o, bomb_blue_o}, 12'hE33);
        reset_ni = 1'b1;

        // first bomb after cooldown of 3 frames
        repeat (3) begin
            step(3);
            frame_pulse();
        end
        chk("cool_wait", bomb_o, 0);
        step(3);
        frame_pulse();
        chk("fire_bomb", bomb_o, 1);
        chk("fire_top", bomb_top_o, 200);
        chk("fire_left", bomb_left_o, exp_left(100, 200, int'(f_lfsr)));
        chk("fire_state", state_o, 2'b10);

        // fall, freeze while disabled, then hit the floor
        frames(10);
        chk("fall_top", bomb_top_o, 260);
        enable_i = 1'b0;
        frames(10);
        chk("freeze_top", bomb_top_o, 260);
        chk("freeze_bomb", bomb_o, 1);
        enable_i = 1'b1;
        frames(34);
        chk("pre_floor", bomb_top_o, 464);
        frames(1);
        chk("floor_top", bomb_top_o, 470);
        chk("floor_vis", bomb_o, 1);
        step(1);
        chk("floor_gone", bomb_o, 0);
        chk("floor_nohit", hit_player_o, 0);

        // minimum spacing then second bomb
        frames(3);
        chk("space_wait", bomb_o, 0);
        frames(1);
        chk("fire2_bomb", bomb_o, 1);
        chk("fire2_left", bomb_left_o, exp_left(100, 200, int'(f_lfsr)));

        // clear mid-flight
        frames(2);
        chk("fall2_top", bomb_top_o, 212);
        clear_i = 1'b1;
        step(1);
        clear_i = 1'b0;
        chk("clr_state", state_o, 2'b01);
        chk("clr_bomb", bomb_o, 0);
        chk("clr_hit", hit_player_o, 0);
        chk("clr_clash", clash_o, 0);

        // narrow fleet pins the column at 265; clear beats a fire frame
        fleet_left_i = 10'd259;
        fleet_right_i = 10'd271;
        player_left_i = 10'd249;
        player_right_i = 10'd289;
        frames(3);
        chk("cool3_wait", bomb_o, 0);
        step(1);
        clear_i = 1'b1;
        frame_pulse();
        clear_i = 1'b0;
        chk("clr_nofire", bomb_o, 0);
        frames(3);
        chk("reload_wait", bomb_o, 0);
        frames(1);
        chk("fire3_bomb", bomb_o, 1);
        chk("fire3_left", bomb_left_o, 265);

        // player hit
        frames(30);
        chk("hit_pre", bomb_top_o, 380);
        frames(1);
        chk("hit_top", bomb_top_o, 386);
        chk("hit_early", hit_player_o, 0);
        step(1);
        chk("hit_pulse", hit_player_o, 1);
        chk("hit_bomb", bomb_o, 0);
        chk("hit_state", state_o, 2'b01);
        step(1);
        chk("hit_once", hit_player_o, 0);
        frames(3);
        chk("hit_cool", bomb_o, 0);
        frames(1);
        chk("fire4_bomb", bomb_o, 1);

        // clash with player bullet
        player_left_i = 10'd9;
        player_right_i = 10'd49;
        pbullet_i = 1'b1;
        pbullet_left_i = 10'd263;
        pbullet_top_i = 10'd300;
        frames(15);
        chk("clash_pre", bomb_top_o, 290);
        chk("clash_none", clash_o, 0);
        frames(1);
        chk("clash_top", bomb_top_o, 296);
        step(1);
        chk("clash_pulse", clash_o, 1);
        chk("clash_bomb", bomb_o, 0);
        chk("clash_nohit", hit_player_o, 0);
        step(1);
        chk("clash_once", clash_o, 0);

        // hit and clash together: hit wins
        pbullet_i = 1'b0;
        frames(4);
        chk("fire5_bomb", bomb_o, 1);
        player_left_i = 10'd249;
        player_right_i = 10'd289;
        pbullet_i = 1'b1;
        pbullet_top_i = 10'd392;
        frames(31);
        chk("both_top", bomb_top_o, 386);
        step(1);
        chk("both_hit", hit_player_o, 1);
        chk("both_noclash", clash_o, 0);
        chk("both_bomb", bomb_o, 0);
        step(1);
        chk("hit_total", hit_cnt, 2);
        chk("clash_total", clash_cnt, 1);

        // asynchronous reset mid-flight
        pbullet_i = 1'b0;
        frames(4);
        chk("fire6_bomb", bomb_o, 1);
        frames(5);
        chk("fall6_top", bomb_top_o, 230);
        #2 reset_ni = 1'b0;
        #1;
        chk("arst_bomb", bomb_o, 0);
        chk("arst_state", state_o, 2'b01);
        chk("arst_top", bomb_top_o, 0);
        chk("arst_bot", bomb_bot_o, 10);
        chk("arst_right", bomb_right_o, 6);
        chk("arst_hit", hit_player_o, 0);
        chk("arst_clash", clash_o, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
